// File: rtl/write_ptr_ctrl.sv
// rtl/write_ptr_ctrl.sv - FIFO write-side pointer with full/almost-full/level/overflow flags; optional WRITE_PTR_SYNC_EN read-pointer synchroniser
module write_ptr_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_THRESH = (1 << ADDR_SIZE) - 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   rd_ptr_i,
  input  logic                 inc_i,
  input  logic                 clr_ovf_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 fifo_full_o,
  output logic                 almost_full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  // Threshold in pointer width; AF_THRESH may equal the depth, which needs the extra bit.
  localparam logic [ADDR_SIZE:0] AF_LVL    = (ADDR_SIZE+1)'(AF_THRESH);
  // A full FIFO's write pointer equals the read pointer with its two top Gray bits flipped.
  localparam logic [ADDR_SIZE:0] FULL_MASK = (ADDR_SIZE+1)'(3 << (ADDR_SIZE - 1));

  logic [ADDR_SIZE:0] r_wbin;
  logic [ADDR_SIZE:0] r_ptr;
  logic [ADDR_SIZE:0] r_level;
  logic               r_full;
  logic               r_afull;
  logic               r_ovf;

  logic [ADDR_SIZE:0] w_rq;
  logic [ADDR_SIZE:0] w_rbin;
  logic               w_accept;
  logic [ADDR_SIZE:0] w_wbin_next;
  logic [ADDR_SIZE:0] w_gray_next;
  logic [ADDR_SIZE:0] w_level_next;
  logic               w_full_next;
  logic               w_afull_next;

`ifdef WRITE_PTR_SYNC_EN
  logic [ADDR_SIZE:0] r_sync1;
  logic [ADDR_SIZE:0] r_sync2;

  // Two-flop synchroniser bringing the read-domain Gray pointer into this clock domain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rd_ptr_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rq = r_sync2;
`else
  assign w_rq = rd_ptr_i;
`endif

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_rbin[i] = ^(w_rq >> i);
    end
  end

  // Next-pointer and next-flag computation; flags are registered from these values.
  always_comb begin
    w_accept     = inc_i & ~r_full;
    w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_accept};
    w_gray_next  = w_wbin_next ^ (w_wbin_next >> 1);
    w_level_next = w_wbin_next - w_rbin;
    w_full_next  = (w_gray_next == (w_rq ^ FULL_MASK));
    w_afull_next = (w_level_next >= AF_LVL);
  end

  // Pointer, level and full/almost-full registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wbin  <= '0;
      r_ptr   <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_ptr   <= w_gray_next;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
    end
  end

  // Sticky overflow: a rejected write sets it and takes priority over a clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ovf <= 1'b0;
    end else if (inc_i && r_full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign ptr_o         = r_ptr;
  assign addr_o        = r_wbin[ADDR_SIZE-1:0];
  assign fifo_full_o   = r_full;
  assign almost_full_o = r_afull;
  assign level_o       = r_level;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// tb/tb_write_ptr_ctrl.sv - randomized and directed self-checking bench for write_ptr_ctrl
module tb_write_ptr_ctrl;

  localparam int AS    = 2;
  localparam int AF    = 3;
  localparam int DEPTH = 1 << AS;
  localparam int PMOD  = 2 * DEPTH;
`ifdef WRITE_PTR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AS:0]   rd_ptr_i;
  logic          inc_i;
  logic          clr_ovf_i;
  logic [AS:0]   ptr_o;
  logic [AS-1:0] addr_o;
  logic          fifo_full_o;
  logic          almost_full_o;
  logic [AS:0]   level_o;
  logic          overflow_o;

  write_ptr_ctrl #(.ADDR_SIZE(AS), .AF_THRESH(AF)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rd_ptr_i     (rd_ptr_i),
    .inc_i        (inc_i),
    .clr_ovf_i    (clr_ovf_i),
    .ptr_o        (ptr_o),
    .addr_o       (addr_o),
    .fifo_full_o  (fifo_full_o),
    .almost_full_o(almost_full_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: counts of writes/reads, delayed view of the reader.
  int m_wr;
  int m_rd;
  int m_hist[$];
  int m_level;
  bit m_full;
  bit m_ovf;
  bit m_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AS:0] gray(input int b);
    logic [AS:0] v;
    v = b[AS:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0;
    m_rd = 0;
    m_level = 0;
    m_full = 0;
    m_ovf = 0;
    m_acc = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_LAT; i++) m_hist.push_back(0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ptr"},   32'(ptr_o), 0);
    check_eq({tag, "_addr"},  32'(addr_o), 0);
    check_eq({tag, "_level"}, 32'(level_o), 0);
    check_eq({tag, "_full"},  32'(fifo_full_o), 0);
    check_eq({tag, "_af"},    32'(almost_full_o), 0);
    check_eq({tag, "_ovf"},   32'(overflow_o), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    rd_ptr_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_i = 1'b1;
    model_reset();
  endtask

  // One clock edge: advance the model with the inputs presented, then compare.
  task automatic step();
    logic [AS:0] prev_ptr;
    int rb;
    prev_ptr = ptr_o;
    @(posedge clk);
    m_acc = inc_i && !m_full;
    if (m_acc) m_wr = (m_wr + 1) % PMOD;
    m_hist.push_back(m_rd);
    rb = m_hist[m_hist.size() - 1 - SYNC_LAT];
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    m_level = (m_wr - rb + PMOD) % PMOD;
    if (inc_i && m_full) m_ovf = 1;
    else if (clr_ovf_i) m_ovf = 0;
    m_full = (m_level == DEPTH);
    #1;
    check_eq("ptr",    32'(ptr_o), 32'(gray(m_wr)));
    check_eq("addr",   32'(addr_o), 32'(m_wr % DEPTH));
    check_eq("level",  32'(level_o), 32'(m_level));
    check_eq("full",   32'(fifo_full_o), 32'(m_full));
    check_eq("af",     32'(almost_full_o), 32'(m_level >= AF));
    check_eq("ovf",    32'(overflow_o), 32'(m_ovf));
    check_eq("toggle", 32'($countones(ptr_o ^ prev_ptr)), m_acc ? 1 : 0);
  endtask

  initial begin
    int exp_ptr[5];
    int exp_lvl[5];
    int drain_edges;
    bit saw_full;
    bit saw_wrap;
    bit saw_addr_wrap;
    logic [AS:0]   pp;
    logic [AS-1:0] pa;

    rst_i = 1'b0;
    rd_ptr_i = '0;
    inc_i = 1'b0;
    clr_ovf_i = 1'b0;
    model_reset();
    do_reset();

    // Fill with reader idle, one extra write rejected.
    exp_ptr = '{1, 3, 2, 6, 6};
    exp_lvl = '{1, 2, 3, 4, 4};
    inc_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("fill_ptr", 32'(ptr_o), 32'(exp_ptr[i]));
      check_eq("fill_level", 32'(level_o), 32'(exp_lvl[i]));
      check_eq("fill_af", 32'(almost_full_o), (i >= 2) ? 1 : 0);
      check_eq("fill_full", 32'(fifo_full_o), (i >= 3) ? 1 : 0);
    end
    check_eq("fill_ovf", 32'(overflow_o), 1);

    // Overflow clear, then clear racing a rejected write.
    inc_i = 1'b0;
    clr_ovf_i = 1'b1;
    step();
    check_eq("ovf_clr", 32'(overflow_o), 0);
    inc_i = 1'b1;
    step();
    check_eq("ovf_set_wins", 32'(overflow_o), 1);
    inc_i = 1'b0;
    step();
    clr_ovf_i = 1'b0;

    // Drain: reader jumps to binary 2.
    m_rd = 2;
    rd_ptr_i = gray(m_rd);
    drain_edges = 0;
    for (int k = 1; k <= SYNC_LAT + 3; k++) begin
      step();
      if (!fifo_full_o && drain_edges == 0) drain_edges = k;
    end
    check_eq("drain_edges", 32'(drain_edges), 32'(SYNC_LAT + 1));
    check_eq("drain_level", 32'(level_o), 2);

    // Wrap: reader one entry behind the writer for 10 writes.
    do_reset();
    saw_full = 0;
    saw_wrap = 0;
    saw_addr_wrap = 0;
    inc_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pp = ptr_o;
      pa = addr_o;
      step();
      if (fifo_full_o) saw_full = 1;
      if (pp == 3'b100 && ptr_o == 3'b000) saw_wrap = 1;
      if (pa == 2'b11 && addr_o == 2'b00) saw_addr_wrap = 1;
      m_rd = (m_wr - 1 + PMOD) % PMOD;
      rd_ptr_i = gray(m_rd);
    end
    check_eq("wrap_ptr", 32'(saw_wrap), 1);
    check_eq("wrap_addr", 32'(saw_addr_wrap), 1);
    check_eq("wrap_nofull", 32'(saw_full), 0);

    // Mid-stream asynchronous reset at level 3.
    do_reset();
    inc_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("pre_rst_level", 32'(level_o), 3);
    inc_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rst_i = 1'b1;
    model_reset();
    rd_ptr_i = '0;
    inc_i = 1'b1;
    step();
    check_eq("post_rst_ptr", 32'(ptr_o), 1);
    check_eq("post_rst_level", 32'(level_o), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      inc_i = ($urandom_range(0, 3) != 0);
      clr_ovf_i = ($urandom_range(0, 7) == 0);
      if (((m_wr - m_rd + PMOD) % PMOD) > 0 && $urandom_range(0, 1) == 1) begin
        m_rd = (m_rd + 1) % PMOD;
        rd_ptr_i = gray(m_rd);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
